// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and bubble counter
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm,
    input  logic [31:0]      id_pc4,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic [1:0]       id_alu_op,
    output logic [31:0]      ex_rs_data,
    output logic [31:0]      ex_rt_data,
    output logic [31:0]      ex_imm,
    output logic [31:0]      ex_pc4,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_reg_dst,
    output logic [1:0]       ex_alu_op,
    output logic             ex_valid,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [1:0]  alu_op;
    } stage_t;

    stage_t            stage_q, stage_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;
    logic              load_bubble;

    // Only the one-cycle load-use case stalls; other RAW hazards are forwarded in EX.
    assign hazard = stage_q.valid & stage_q.mem_read & (stage_q.rt != 5'd0) & id_valid &
                    ((stage_q.rt == id_rs) | (id_uses_rt & (stage_q.rt == id_rt)));
    assign stall       = hazard & ~flush;
    assign load_bubble = flush | hazard;

    always_comb begin
        stage_d = '0;
        if (!load_bubble) begin
            stage_d.valid      = id_valid;
            stage_d.rs_data    = id_rs_data;
            stage_d.rt_data    = id_rt_data;
            stage_d.imm        = id_imm;
            stage_d.pc4        = id_pc4;
            stage_d.rs         = id_rs;
            stage_d.rt         = id_rt;
            stage_d.rd         = id_rd;
            stage_d.reg_write  = id_reg_write;
            stage_d.mem_to_reg = id_mem_to_reg;
            stage_d.mem_read   = id_mem_read;
            stage_d.mem_write  = id_mem_write;
            stage_d.alu_src    = id_alu_src;
            stage_d.reg_dst    = id_reg_dst;
            stage_d.alu_op     = id_alu_op;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid      = stage_q.valid;
    assign ex_rs_data    = stage_q.rs_data;
    assign ex_rt_data    = stage_q.rt_data;
    assign ex_imm        = stage_q.imm;
    assign ex_pc4        = stage_q.pc4;
    assign ex_rs         = stage_q.rs;
    assign ex_rt         = stage_q.rt;
    assign ex_rd         = stage_q.rd;
    assign ex_reg_write  = stage_q.reg_write;
    assign ex_mem_to_reg = stage_q.mem_to_reg;
    assign ex_mem_read   = stage_q.mem_read;
    assign ex_mem_write  = stage_q.mem_write;
    assign ex_alu_src    = stage_q.alu_src;
    assign ex_reg_dst    = stage_q.reg_dst;
    assign ex_alu_op     = stage_q.alu_op;
    assign bubble_cnt    = cnt_q;

endmodule
